vga_tile_scan: RTL and testbench
================================

Name: vga_tile_scan

Overview:
- Raster timing generator producing the tile-coordinate stream (M_ColCountDiv, M_RowCountDiv) that object blocks such as the meteorite, ship and bullet compare against their positions to assert draw flags.
- Runs a 640x480 VGA scan (800x525 total) on the pixel clock.
- Outputs HSync/VSync, active-video flag, raw pixel counters, tile counters (pixel >> c_TileShift, 40x30 grid) and a once-per-frame tick that game logic uses for frame-rate updates.

Parameters:
- c_TotalCols, 800, pixels per line including blanking
- c_TotalRows, 525, lines per frame including blanking
- c_ActiveCols, 640, visible pixels per line
- c_ActiveRows, 480, visible lines per frame
- c_HFrontPorch, 16, pixels between active end and HSync start
- c_HSyncWidth, 96, HSync pulse width in pixels
- c_VFrontPorch, 10, lines between active end and VSync start
- c_VSyncWidth, 2, VSync pulse width in lines
- c_TileShift, 4, log2 of tile size in pixels (16 -> 40x30 tiles)

Ports:
- i_Clk  in  1  pixel clock (25.175 MHz nominal)
- i_Reset  in  1  asynchronous, active-high reset
- o_HSync  out  1  horizontal sync, active low
- o_VSync  out  1  vertical sync, active low
- o_Active  out  1  high while the output pixel is visible
- o_ColCount  out  10  raw column counter, 0..c_TotalCols-1
- o_RowCount  out  10  raw row counter, 0..c_TotalRows-1
- M_ColCountDiv  out  6  column tile index
- M_RowCountDiv  out  6  row tile index
- o_FrameTick  out  1  one-cycle pulse at start of vertical blanking

Behaviour:
- Reset (async assert, sync release):
  - counters = 0; o_HSync = 1; o_VSync = 1; o_Active = 0; o_FrameTick = 0; tile outputs = 0.
  - First edge after release computes outputs for count (0,0).
- Column counter: increments every clock; at c_TotalCols-1 it wraps to 0 and the row counter advances.
- Row counter: wraps from c_TotalRows-1 to 0 on the same edge the column counter wraps. Both wrap together at (799,524) -> (0,0).
- o_ColCount / o_RowCount: the live counter registers (0-cycle latency).
- All other outputs are registered decodes of the current counters, so they lag the counters by exactly 1 cycle. Consumers that register their draw flag see a total of 2 cycles from counter to draw; the sync outputs are aligned to that 2-cycle pipeline through an extra stage.
  - Net result: o_HSync / o_VSync / o_Active lag o_ColCount by 2 cycles; M_*Div and o_FrameTick lag by 1 cycle.
- HSync low while col is in [c_ActiveCols+c_HFrontPorch, c_ActiveCols+c_HFrontPorch+c_HSyncWidth-1], i.e. 656..751.
- VSync low while row is in [c_ActiveRows+c_VFrontPorch, c_ActiveRows+c_VFrontPorch+c_VSyncWidth-1], i.e. 490..491, for the full line width.
- Active = (col < c_ActiveCols) and (row < c_ActiveRows).
- Tile outputs (default build): col >> c_TileShift and row >> c_TileShift, truncated to 6 bits.
  - Columns run 0..49; rows run 0..32.
  - Values 40..49 (cols) and 30..32 (rows) occur only during blanking.
- o_FrameTick: high for one cycle when the counters are at (0, c_ActiveRows), i.e. (0,480). It never fires during reset.
- Reset mid-frame: all outputs return to reset values immediately (async). The scan restarts at (0,0); no partial-frame tick is emitted.
- No other inputs; the block is free-running.

Optional Feature:
- Macro TILE_BLANK_CLAMP_EN.
- Defined: M_ColCountDiv and M_RowCountDiv are forced to 6'h3F whenever the pixel is outside the active area (same pipeline stage as o_Active). Off-screen parked objects, such as the meteorite reset position (40,30), can therefore never match during blanking.
- Undefined: raw shifted values are output as described in Behaviour.

Test Plan:
- Reset held 5 cycles, then released -> during reset HSync=1, VSync=1, Active=0, M_ColCountDiv=0, M_RowCountDiv=0; after release o_ColCount counts 0,1,2.
- Run one line -> o_HSync low for exactly 96 clocks, first low output 2 cycles after o_ColCount=656; o_Active high for exactly 640 clocks per line on rows 0..479.
- Run a full frame -> o_VSync low for exactly 1600 clocks (rows 490..491); one o_FrameTick per 420000 clocks, 1 cycle after counters reach (0,480).
- Check tiles at counter (639,479) -> next cycle M_ColCountDiv=39, M_RowCountDiv=29. At (799,524) -> 49/32 (default build) or 63/63 (TILE_BLANK_CLAMP_EN).
- Assert i_Reset asynchronously at counter (300,200) between clock edges -> outputs take reset values before the next edge; after release the first o_FrameTick arrives after exactly 480*800 + 1 cycles.
- Wrap check: counter (799,524) -> next edge (0,0); Active rises 2 cycles later and M_*Div=0/0 1 cycle later.

Source files
------------

// File: rtl/vga_tile_scan.sv
// 640x480 raster scan with tile-coordinate stream; counters live, tiles/tick lag 1 cycle, syncs/active lag 2; free-running, no backpressure.
// Optional TILE_BLANK_CLAMP_EN forces tile outputs to 6'h3F outside the visible area.
module vga_tile_scan #(
  parameter int c_TotalCols  = 800,
  parameter int c_TotalRows  = 525,
  parameter int c_ActiveCols = 640,
  parameter int c_ActiveRows = 480,
  parameter int c_HFrontPorch = 16,
  parameter int c_HSyncWidth  = 96,
  parameter int c_VFrontPorch = 10,
  parameter int c_VSyncWidth  = 2,
  parameter int c_TileShift   = 4
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_Active,
  output logic [9:0] o_ColCount,
  output logic [9:0] o_RowCount,
  output logic [5:0] M_ColCountDiv,
  output logic [5:0] M_RowCountDiv,
  output logic       o_FrameTick
);

  localparam logic [9:0] c_ColLast   = 10'(c_TotalCols - 1);
  localparam logic [9:0] c_RowLast   = 10'(c_TotalRows - 1);
  localparam logic [9:0] c_ColActive = 10'(c_ActiveCols);
  localparam logic [9:0] c_RowActive = 10'(c_ActiveRows);
  localparam logic [9:0] c_HsStart   = 10'(c_ActiveCols + c_HFrontPorch);
  localparam logic [9:0] c_HsEnd     = 10'(c_ActiveCols + c_HFrontPorch + c_HSyncWidth - 1);
  localparam logic [9:0] c_VsStart   = 10'(c_ActiveRows + c_VFrontPorch);
  localparam logic [9:0] c_VsEnd     = 10'(c_ActiveRows + c_VFrontPorch + c_VSyncWidth - 1);

  logic [9:0] col_count;
  logic [9:0] row_count;

  logic       h_sync_d;
  logic       v_sync_d;
  logic       active_d;
  logic       tick_d;
  logic [5:0] col_tile_d;
  logic [5:0] row_tile_d;

  logic       h_sync_s1;
  logic       v_sync_s1;
  logic       active_s1;

  assign o_ColCount = col_count;
  assign o_RowCount = row_count;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      col_count <= '0;
      row_count <= '0;
    end else if (col_count == c_ColLast) begin
      col_count <= '0;
      row_count <= (row_count == c_RowLast) ? '0 : row_count + 10'd1;
    end else begin
      col_count <= col_count + 10'd1;
    end
  end

  always_comb begin
    h_sync_d   = !((col_count >= c_HsStart) && (col_count <= c_HsEnd));
    v_sync_d   = !((row_count >= c_VsStart) && (row_count <= c_VsEnd));
    active_d   = (col_count < c_ColActive) && (row_count < c_RowActive);
    tick_d     = (col_count == 10'd0) && (row_count == c_RowActive);
`ifdef TILE_BLANK_CLAMP_EN
    // Parked objects sit at off-screen tile coordinates; 3F matches nothing.
    col_tile_d = active_d ? col_count[c_TileShift +: 6] : 6'h3F;
    row_tile_d = active_d ? row_count[c_TileShift +: 6] : 6'h3F;
`else
    col_tile_d = col_count[c_TileShift +: 6];
    row_tile_d = row_count[c_TileShift +: 6];
`endif
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      h_sync_s1     <= 1'b1;
      v_sync_s1     <= 1'b1;
      active_s1     <= 1'b0;
      M_ColCountDiv <= '0;
      M_RowCountDiv <= '0;
      o_FrameTick   <= 1'b0;
    end else begin
      h_sync_s1     <= h_sync_d;
      v_sync_s1     <= v_sync_d;
      active_s1     <= active_d;
      M_ColCountDiv <= col_tile_d;
      M_RowCountDiv <= row_tile_d;
      o_FrameTick   <= tick_d;
    end
  end

  // Extra stage lines syncs up with consumers that register their draw flag.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_HSync  <= 1'b1;
      o_VSync  <= 1'b1;
      o_Active <= 1'b0;
    end else begin
      o_HSync  <= h_sync_s1;
      o_VSync  <= v_sync_s1;
      o_Active <= active_s1;
    end
  end

endmodule

// File: tb/tb_vga_tile_scan.sv
// Directed bench for vga_tile_scan; counters are jumped with force/release to reach far raster positions quickly.
module tb_vga_tile_scan;

  logic       i_Clk = 1'b0;
  logic       i_Reset;
  logic       o_HSync;
  logic       o_VSync;
  logic       o_Active;
  logic [9:0] o_ColCount;
  logic [9:0] o_RowCount;
  logic [5:0] M_ColCountDiv;
  logic [5:0] M_RowCountDiv;
  logic       o_FrameTick;

  int checks = 0;
  int failures = 0;

  vga_tile_scan dut (
    .i_Clk(i_Clk),
    .i_Reset(i_Reset),
    .o_HSync(o_HSync),
    .o_VSync(o_VSync),
    .o_Active(o_Active),
    .o_ColCount(o_ColCount),
    .o_RowCount(o_RowCount),
    .M_ColCountDiv(M_ColCountDiv),
    .M_RowCountDiv(M_RowCountDiv),
    .o_FrameTick(o_FrameTick)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  // Place the counters at (c,r) so that the next rising edge advances from there.
  task automatic jump(input int c, input int r);
    @(negedge i_Clk);
    force dut.col_count = 10'(c);
    force dut.row_count = 10'(r);
    #1;
    release dut.col_count;
    release dut.row_count;
  endtask

  initial begin
    int hs_low;
    int act_hi;
    int vs_low;
    int c656;
    int first_low;
    int ticks;
    int tick_at;
    int tick_col;
    int tick_row;

    // Reset held 5 cycles
    i_Reset = 1'b1;
    cyc(5);
    chk("rst_hsync", o_HSync, 1);
    chk("rst_vsync", o_VSync, 1);
    chk("rst_active", o_Active, 0);
    chk("rst_coldiv", M_ColCountDiv, 0);
    chk("rst_rowdiv", M_RowCountDiv, 0);
    chk("rst_tick", o_FrameTick, 0);
    chk("rst_col", o_ColCount, 0);
    i_Reset = 1'b0;
    chk("rel_col0", o_ColCount, 0);
    cyc(1);
    chk("rel_col1", o_ColCount, 1);
    chk("rel_row0", o_RowCount, 0);
    cyc(1);
    chk("rel_col2", o_ColCount, 2);

    // One full line of HSync and Active
    hs_low = 0; act_hi = 0; c656 = -1; first_low = -1;
    for (int i = 0; i < 800; i++) begin
      cyc(1);
      if (o_HSync === 1'b0) hs_low++;
      if (o_Active === 1'b1) act_hi++;
      if (o_ColCount == 10'd656 && c656 < 0) c656 = i;
      if (o_HSync === 1'b0 && first_low < 0) first_low = i;
    end
    chk("line_hsync_low", hs_low, 96);
    chk("line_active_hi", act_hi, 640);
    chk("line_hsync_lag", first_low - c656, 2);

    // VSync across rows 488..492
    jump(0, 488);
    vs_low = 0;
    for (int i = 0; i < 3300; i++) begin
      cyc(1);
      if (o_VSync === 1'b0) vs_low++;
    end
    chk("frame_vsync_low", vs_low, 1600);

    // Frame tick around (0,480)
    jump(795, 479);
    ticks = 0; tick_at = -1; tick_col = -1; tick_row = -1;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (o_FrameTick === 1'b1) begin
        ticks++;
        if (tick_at < 0) begin
          tick_at = i; tick_col = int'(o_ColCount); tick_row = int'(o_RowCount);
        end
      end
    end
    chk("tick_count", ticks, 1);
    chk("tick_at", tick_at, 6);
    chk("tick_col", tick_col, 1);
    chk("tick_row", tick_row, 480);

    // Last visible tile
    jump(639, 479);
    cyc(1);
    chk("tile_last_col", o_ColCount, 640);
    chk("tile_last_cdiv", M_ColCountDiv, 39);
    chk("tile_last_rdiv", M_RowCountDiv, 29);

    // Frame wrap
    jump(799, 524);
    cyc(1);
    chk("wrap_col", o_ColCount, 0);
    chk("wrap_row", o_RowCount, 0);
`ifdef TILE_BLANK_CLAMP_EN
    chk("wrap_cdiv_blank", M_ColCountDiv, 63);
    chk("wrap_rdiv_blank", M_RowCountDiv, 63);
`else
    chk("wrap_cdiv_blank", M_ColCountDiv, 49);
    chk("wrap_rdiv_blank", M_RowCountDiv, 32);
`endif
    cyc(1);
    chk("wrap_cdiv0", M_ColCountDiv, 0);
    chk("wrap_rdiv0", M_RowCountDiv, 0);
    chk("wrap_active_lo", o_Active, 0);
    cyc(1);
    chk("wrap_active_hi", o_Active, 1);
    chk("wrap_hsync", o_HSync, 1);

    // Asynchronous reset mid-frame at (300,200)
    jump(299, 200);
    cyc(1);
    chk("mid_col", o_ColCount, 300);
    chk("mid_cdiv", M_ColCountDiv, 18);
    chk("mid_rdiv", M_RowCountDiv, 12);
    chk("mid_active", o_Active, 1);
    #2;
    i_Reset = 1'b1;
    #1;
    chk("arst_col", o_ColCount, 0);
    chk("arst_row", o_RowCount, 0);
    chk("arst_active", o_Active, 0);
    chk("arst_cdiv", M_ColCountDiv, 0);
    chk("arst_rdiv", M_RowCountDiv, 0);
    chk("arst_hsync", o_HSync, 1);
    chk("arst_vsync", o_VSync, 1);
    ticks = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      if (o_FrameTick !== 1'b0) ticks++;
    end
    chk("arst_no_tick", ticks, 0);
    i_Reset = 1'b0;
    cyc(1);
    chk("arst_rel_col", o_ColCount, 1);
    chk("arst_rel_row", o_RowCount, 0);
    cyc(1);
    chk("arst_rel_active", o_Active, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
